// File: rtl/td4_seq_ctrl.sv
// Instruction sequencer for a TD4-style 4-bit CPU: IDLE/FETCH/EXEC/HALT control FSM.
// Latency: one instruction every 2 cycles (FETCH, EXEC); strobes are combinational from state.
// Backpressure: none; run/step are only sampled in IDLE (and run at EXEC exit), step is never queued.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   run, step      free-run level and single-step pulse
//   instr          ROM data at the current PC ([7:4] opcode, [3:0] immediate)
//   dec_ld_n       active-low load enables from the decoder ([0] A, [1] B, [2] OUT, [3] PC)
//   pc_co          PC wrap flag
//   ir_op, ir_im   latched instruction fields
//   ld_a, ld_b, ld_out, ld_pc, pc_inc, flag_ld   execute-cycle strobes
//   state, busy, halted                           FSM status
//   instr_cnt      saturating count of executed instructions
module td4_seq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       step,
   input  logic [7:0] instr,
   input  logic [3:0] dec_ld_n,
   input  logic       pc_co,
   output logic [3:0] ir_op,
   output logic [3:0] ir_im,
   output logic       ld_a,
   output logic       ld_b,
   output logic       ld_out,
   output logic       ld_pc,
   output logic       pc_inc,
   output logic       flag_ld,
   output logic [1:0] state,
   output logic       busy,
   output logic       halted,
   output logic [7:0] instr_cnt
);

   // Encoding is visible on the state port, so values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] ir_op_q, ir_op_d;
   logic [3:0] ir_im_q, ir_im_d;
   logic [7:0] cnt_q, cnt_d;

   // ------------------------------------------------------------------
   // State registers. Reset is asynchronous so that an instruction in
   // flight is aborted the moment rst rises: every strobe is decoded from
   // state_q, so forcing IDLE here drops them without waiting for a clock.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ir_op_q <= 4'h0;
         ir_im_q <= 4'h0;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         ir_op_q <= ir_op_d;
         ir_im_q <= ir_im_d;
         cnt_q   <= cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and strobe decode.
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ir_op_d = ir_op_q;
      ir_im_d = ir_im_q;
      cnt_d   = cnt_q;
      ld_a    = 1'b0;
      ld_b    = 1'b0;
      ld_out  = 1'b0;
      ld_pc   = 1'b0;
      pc_inc  = 1'b0;
      flag_ld = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // run and step together behave as run: both lead to FETCH,
            // and the EXEC exit decides whether to continue.
            if (run || step) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            // The instruction register only loads on this edge.
            ir_op_d = instr[7:4];
            ir_im_d = instr[3:0];
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            ld_a    = ~dec_ld_n[0];
            ld_b    = ~dec_ld_n[1];
            ld_out  = ~dec_ld_n[2];
            // A jump replaces the increment, so exactly one of the two fires.
            ld_pc   = ~dec_ld_n[3];
            pc_inc  =  dec_ld_n[3];
            flag_ld = 1'b1;

            if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end

            // Running off the end of program memory (wrap without a jump)
            // halts; a jump taken on the wrap cycle does not.
            if (pc_co && dec_ld_n[3]) begin
               state_d = ST_HALT;
            end else if (run) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_HALT: begin
            // Sticky until reset.
            state_d = ST_HALT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign ir_op     = ir_op_q;
   assign ir_im     = ir_im_q;
   assign state     = state_q;
   assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
   assign halted    = (state_q == ST_HALT);
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_td4_seq_ctrl.sv
// Self-checking bench for td4_seq_ctrl: directed vector table, hand-written
// reset/halt/saturation sequences, and a randomized run against a reference model.
module tb_td4_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       step;
   logic [7:0] instr;
   logic [3:0] dec_ld_n;
   logic       pc_co;
   logic [3:0] ir_op;
   logic [3:0] ir_im;
   logic       ld_a, ld_b, ld_out, ld_pc, pc_inc, flag_ld;
   logic [1:0] state;
   logic       busy;
   logic       halted;
   logic [7:0] instr_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   td4_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .step      (step),
      .instr     (instr),
      .dec_ld_n  (dec_ld_n),
      .pc_co     (pc_co),
      .ir_op     (ir_op),
      .ir_im     (ir_im),
      .ld_a      (ld_a),
      .ld_b      (ld_b),
      .ld_out    (ld_out),
      .ld_pc     (ld_pc),
      .pc_inc    (pc_inc),
      .flag_ld   (flag_ld),
      .state     (state),
      .busy      (busy),
      .halted    (halted),
      .instr_cnt (instr_cnt)
   );

   wire [5:0]  stb     = {ld_a, ld_b, ld_out, ld_pc, pc_inc, flag_ld};
   wire [25:0] all_out = {state, busy, halted, ir_op, ir_im, stb, instr_cnt};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       run;
      logic       step;
      logic [7:0] instr;
      logic [3:0] dec;
      logic       pco;
      logic [1:0] st;   // state expected during this cycle
      logic [5:0] stb;  // {ld_a, ld_b, ld_out, ld_pc, pc_inc, flag_ld}
      logic [7:0] ir;   // {ir_op, ir_im}
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl [14];

   // ---------------- reference model ----------------
   // m_st: 0 idle, 1 fetch, 2 exec, 3 halt (matches the visible state code)
   int         m_st;
   logic [7:0] m_ir;
   int         m_cnt;

   task automatic model_reset();
      m_st  = 0;
      m_ir  = 8'h00;
      m_cnt = 0;
   endtask

   task automatic model_clock();
      case (m_st)
         0: if (run || step) m_st = 1;
         1: begin m_ir = instr; m_st = 2; end
         2: begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (pc_co && dec_ld_n[3]) m_st = 3;
            else if (run)             m_st = 1;
            else                      m_st = 0;
         end
         default: m_st = 3;
      endcase
   endtask

   function automatic logic [25:0] model_out();
      logic [1:0] s;
      logic [5:0] e;
      logic [7:0] c;
      s = 2'(m_st);
      c = 8'(m_cnt);
      e = (m_st == 2) ? {~dec_ld_n[0], ~dec_ld_n[1], ~dec_ld_n[2], ~dec_ld_n[3], dec_ld_n[3], 1'b1}
                      : 6'b0;
      return {s, (m_st == 1 || m_st == 2), (m_st == 3), m_ir, e, c};
   endfunction

   initial begin
      int execs;
      int exp_cnt;

      tbl[0]  = '{1'b0, 1'b1, 8'h35, 4'b1110, 1'b0, 2'b00, 6'b000000, 8'h00, 8'd0};
      tbl[1]  = '{1'b0, 1'b1, 8'h35, 4'b1110, 1'b0, 2'b01, 6'b000000, 8'h00, 8'd0};
      tbl[2]  = '{1'b0, 1'b1, 8'h35, 4'b1110, 1'b0, 2'b10, 6'b100011, 8'h35, 8'd0};
      tbl[3]  = '{1'b0, 1'b0, 8'h35, 4'b1110, 1'b0, 2'b00, 6'b000000, 8'h35, 8'd1};
      tbl[4]  = '{1'b1, 1'b0, 8'hF7, 4'b0111, 1'b0, 2'b00, 6'b000000, 8'h35, 8'd1};
      tbl[5]  = '{1'b1, 1'b0, 8'hF7, 4'b0111, 1'b0, 2'b01, 6'b000000, 8'h35, 8'd1};
      tbl[6]  = '{1'b1, 1'b0, 8'hF7, 4'b0111, 1'b1, 2'b10, 6'b000101, 8'hF7, 8'd1};
      tbl[7]  = '{1'b0, 1'b0, 8'h42, 4'b1011, 1'b0, 2'b01, 6'b000000, 8'hF7, 8'd2};
      tbl[8]  = '{1'b0, 1'b0, 8'h42, 4'b1011, 1'b0, 2'b10, 6'b001011, 8'h42, 8'd2};
      tbl[9]  = '{1'b0, 1'b0, 8'h42, 4'b1011, 1'b0, 2'b00, 6'b000000, 8'h42, 8'd3};
      tbl[10] = '{1'b0, 1'b1, 8'hA9, 4'b1111, 1'b0, 2'b00, 6'b000000, 8'h42, 8'd3};
      tbl[11] = '{1'b0, 1'b0, 8'hA9, 4'b1111, 1'b0, 2'b01, 6'b000000, 8'h42, 8'd3};
      tbl[12] = '{1'b0, 1'b0, 8'hA9, 4'b1111, 1'b1, 2'b10, 6'b000011, 8'hA9, 8'd3};
      tbl[13] = '{1'b1, 1'b1, 8'hA9, 4'b1111, 1'b0, 2'b11, 6'b000000, 8'hA9, 8'd4};

      // ---- reset held for 2 cycles with run=1 ----
      rst = 1'b1; run = 1'b1; step = 1'b0; instr = 8'h00; dec_ld_n = 4'b1110; pc_co = 1'b0;
      next_cycle();
      next_cycle();
      check("reset_all_outputs", 32'(all_out), 32'd0);
      rst = 1'b0;
      #3;
      check("post_release_still_idle", 32'(state), 32'd0);
      next_cycle();
      check("release_to_fetch", 32'(state), 32'd1);
      next_cycle();
      #2;
      check("exec_strobes_before_abort", 32'(stb), 32'b100011);
      // asynchronous abort mid-EXEC, between clock edges
      rst = 1'b1;
      #1;
      check("abort_strobes_low", 32'(stb), 32'd0);
      check("abort_state_idle", 32'(state), 32'd0);
      check("abort_cnt_zero", 32'(instr_cnt), 32'd0);
      run = 1'b0;
      next_cycle();
      rst = 1'b0;

      // ---- vector table: step, jump, run-stop, halt on wrap ----
      foreach (tbl[i]) begin
         run = tbl[i].run; step = tbl[i].step; instr = tbl[i].instr;
         dec_ld_n = tbl[i].dec; pc_co = tbl[i].pco;
         #3;
         check($sformatf("tbl%0d_state", i),  32'(state), 32'(tbl[i].st));
         check($sformatf("tbl%0d_strobe", i), 32'(stb), 32'(tbl[i].stb));
         check($sformatf("tbl%0d_ir", i),     32'({ir_op, ir_im}), 32'(tbl[i].ir));
         check($sformatf("tbl%0d_cnt", i),    32'(instr_cnt), 32'(tbl[i].cnt));
         check($sformatf("tbl%0d_busy_halted", i), 32'({busy, halted}),
               32'({tbl[i].st == 2'b01 || tbl[i].st == 2'b10, tbl[i].st == 2'b11}));
         next_cycle();
      end

      // ---- HALT is sticky for 10 cycles of run+step ----
      for (int i = 0; i < 10; i++) begin
         run = 1'b1; step = 1'b1; pc_co = 1'b0;
         #3;
         check("halt_sticky", 32'({state, halted, stb, instr_cnt}), 32'({2'b11, 1'b1, 6'b0, 8'd4}));
         next_cycle();
      end
      rst = 1'b1; run = 1'b0; step = 1'b0;
      #3;
      check("halt_exit_by_reset", 32'(all_out), 32'd0);
      next_cycle();

      // ---- saturation: 260 instructions under continuous run ----
      run = 1'b1;
      rst = 1'b0;
      next_cycle();
      execs = 0;
      for (int i = 0; i < 520; i++) begin
         dec_ld_n = 4'($urandom);
         // a wrap only halts without a jump; avoid that combination here
         pc_co = dec_ld_n[3] ? 1'b0 : 1'($urandom);
         instr = 8'($urandom);
         #3;
         exp_cnt = (execs > 255) ? 255 : execs;
         check("sat_state", 32'(state), (i % 2 == 0) ? 32'd1 : 32'd2);
         check("sat_cnt", 32'(instr_cnt), 32'(exp_cnt));
         if (i % 2 == 1) begin
            check("sat_pc_onehot", 32'({ld_pc, pc_inc}), dec_ld_n[3] ? 32'b01 : 32'b10);
            execs++;
         end
         next_cycle();
      end
      #3;
      check("sat_final_cnt", 32'(instr_cnt), 32'hFF);

      // ---- randomized run against the reference model ----
      rst = 1'b1;
      model_reset();
      next_cycle();
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 99) < 3);
         run      = 1'($urandom);
         step     = ($urandom_range(0, 3) == 0);
         instr    = 8'($urandom);
         dec_ld_n = 4'($urandom);
         pc_co    = ($urandom_range(0, 7) == 0);
         if (rst) model_reset();
         #3;
         check("rand_outputs", 32'(all_out), 32'(model_out()));
         @(posedge clk);
         if (!rst) model_clock();
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
